// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the CNN pixel fetch path:
//   - default image dimensions
//   - fetch FSM state encoding
//   - OBI manager configuration and the request/response struct types
//     (32-bit address and data, single-bit transaction id)
// -----------------------------------------------------------------------------
package cnn_pkg;

    localparam int unsigned DefaultImgW = 28;
    localparam int unsigned DefaultImgH = 28;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT   = 2'd2,
        ST_STREAM = 2'd3
    } fetch_state_e;

    typedef struct packed {
        int unsigned AddrWidth;
        int unsigned DataWidth;
        int unsigned IdWidth;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{AddrWidth: 32, DataWidth: 32, IdWidth: 1};

    // OBI address channel (manager -> subordinate)
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [0:0]  aid;
    } obi_a_chan_t;

    typedef struct packed {
        logic        req;
        obi_a_chan_t a;
    } obi_req_t;

    // OBI response channel (subordinate -> manager)
    typedef struct packed {
        logic [31:0] rdata;
        logic [0:0]  rid;
        logic        err;
    } obi_r_chan_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        obi_r_chan_t r;
    } obi_rsp_t;

    // Counter width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/cnn_word_unpack.sv
// -----------------------------------------------------------------------------
// cnn_word_unpack
// Holds one 32-bit memory word and streams it out as DATA_WIDTH-bit pixels,
// lowest lane first, under a valid/ready handshake.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   i_load               capture i_word and start streaming i_count lanes
//   i_word               word to unpack
//   i_count              number of lanes to emit from this word (1..LANES)
//   pixel_o              current pixel
//   pixel_valid_o        pixel_o is valid
//   pixel_ready_i        downstream accepts pixel_o this cycle
//   o_word_done          pulses with the transfer of the word's final pixel
// -----------------------------------------------------------------------------
module cnn_word_unpack #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LANES      = 32 / DATA_WIDTH,
    parameter int unsigned CNT_W      = $clog2(LANES + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  i_load,
    input  logic [31:0]           i_word,
    input  logic [CNT_W-1:0]      i_count,
    output logic [DATA_WIDTH-1:0] pixel_o,
    output logic                  pixel_valid_o,
    input  logic                  pixel_ready_i,
    output logic                  o_word_done
);

    localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [31:0]           r_word;
    logic [IDX_W-1:0]      r_idx;
    logic [CNT_W-1:0]      r_count;
    logic                  r_valid;

    logic [DATA_WIDTH-1:0] w_lane [LANES];
    logic                  w_xfer;
    logic                  w_last_lane;

    // Little-endian lane split: lane 0 is the least significant slice.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign w_lane[gi] = r_word[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign pixel_o       = w_lane[r_idx];
    assign pixel_valid_o = r_valid;
    assign w_xfer        = r_valid & pixel_ready_i;
    assign w_last_lane   = ((CNT_W'(r_idx) + CNT_W'(1)) == r_count);
    assign o_word_done   = w_xfer & w_last_lane;

    // Word and index only move on load or on an accepted transfer, so the
    // presented pixel holds steady through any stall.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_word  <= '0;
            r_idx   <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_word  <= i_word;
            r_idx   <= '0;
            r_count <= i_count;
            r_valid <= 1'b1;
        end else if (w_xfer) begin
            if (w_last_lane) begin
                r_valid <= 1'b0;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/cnn_pixel_fetch.sv
// -----------------------------------------------------------------------------
// cnn_pixel_fetch
// Fetches one IMG_W x IMG_H frame from memory over an OBI manager port, one
// 32-bit word at a time, and streams it byte by byte to the line buffer.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   start_i           one-cycle start pulse (ignored unless idle)
//   base_addr_i       byte address of the first pixel (must be word aligned)
//   mgr_obi_req_o     OBI read requests
//   mgr_obi_rsp_i     OBI grants and read responses
//   pixel_o           streamed pixel
//   pixel_valid_o     pixel_o valid
//   pixel_ready_i     downstream accepts pixel
//   busy_o            frame fetch in progress
//   done_o            one-cycle pulse at frame end (normal or error)
//   err_o             sticky error (misaligned base or bus error)
// -----------------------------------------------------------------------------
module cnn_pixel_fetch
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned IMG_W      = DefaultImgW,
    parameter int unsigned IMG_H      = DefaultImgH,
    parameter obi_cfg_t    ObiCfg     = ObiDefaultConfig
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [31:0]           base_addr_i,
    output obi_req_t              mgr_obi_req_o,
    input  obi_rsp_t              mgr_obi_rsp_i,
    output logic [DATA_WIDTH-1:0] pixel_o,
    output logic                  pixel_valid_o,
    input  logic                  pixel_ready_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int unsigned PIX_TOTAL  = IMG_W * IMG_H;
    localparam int unsigned LANES      = 32 / DATA_WIDTH;
    localparam int unsigned NUM_WORDS  = (PIX_TOTAL + LANES - 1) / LANES;
    localparam int unsigned PIX_CNT_W  = $clog2(PIX_TOTAL + 1);
    localparam int unsigned WORD_CNT_W = clog2_min1(NUM_WORDS);
    localparam int unsigned LANE_CNT_W = $clog2(LANES + 1);
    localparam int unsigned ADDR_W     = ObiCfg.AddrWidth;

    fetch_state_e          r_state;
    logic [31:0]           r_base;
    logic [WORD_CNT_W-1:0] r_word_cnt;
    logic [PIX_CNT_W-1:0]  r_pix_cnt;
    logic                  r_done;
    logic                  r_err;

    logic [ADDR_W-1:0]     w_addr;
    logic [PIX_CNT_W-1:0]  w_pix_left;
    logic [LANE_CNT_W-1:0] w_lane_cnt;
    logic                  w_load;
    logic                  w_xfer;
    logic                  w_word_done;
    logic                  w_last_word;
    logic                  w_unused_rsp;

    // Address wraps naturally at the top of the address space.
    assign w_addr      = ADDR_W'(r_base) + (ADDR_W'(r_word_cnt) << 2);

    // The last word of a frame may carry fewer than LANES live pixels.
    assign w_pix_left  = PIX_CNT_W'(PIX_TOTAL) - r_pix_cnt;
    assign w_lane_cnt  = (w_pix_left >= PIX_CNT_W'(LANES)) ? LANE_CNT_W'(LANES)
                                                           : LANE_CNT_W'(w_pix_left);

    // Responses are only meaningful while waiting; a stray rvalid seen in any
    // other state (e.g. left over from before a reset) is dropped.
    assign w_load      = (r_state == ST_WAIT) & mgr_obi_rsp_i.rvalid & ~mgr_obi_rsp_i.r.err;
    assign w_xfer      = pixel_valid_o & pixel_ready_i;
    assign w_last_word = (r_word_cnt == WORD_CNT_W'(NUM_WORDS - 1));

    assign w_unused_rsp = mgr_obi_rsp_i.r.rid[0];

    always_comb begin
        mgr_obi_req_o        = '0;
        mgr_obi_req_o.req    = (r_state == ST_REQ);
        mgr_obi_req_o.a.addr = 32'(w_addr);
        mgr_obi_req_o.a.we   = 1'b0;
        mgr_obi_req_o.a.be   = 4'hF;
    end

    assign busy_o = (r_state != ST_IDLE);
    assign done_o = r_done;
    assign err_o  = r_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_base     <= '0;
            r_word_cnt <= '0;
            r_pix_cnt  <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        if (base_addr_i[1:0] == 2'b00) begin
                            r_base     <= base_addr_i;
                            r_err      <= 1'b0;
                            r_word_cnt <= '0;
                            r_pix_cnt  <= '0;
                            r_state    <= ST_REQ;
                        end else begin
                            r_err  <= 1'b1;
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (mgr_obi_rsp_i.gnt) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mgr_obi_rsp_i.rvalid) begin
                        if (mgr_obi_rsp_i.r.err) begin
                            r_err   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_STREAM;
                        end
                    end
                end
                ST_STREAM: begin
                    if (w_xfer) begin
                        r_pix_cnt <= r_pix_cnt + PIX_CNT_W'(1);
                    end
                    if (w_word_done) begin
                        if (w_last_word) begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_word_cnt <= r_word_cnt + WORD_CNT_W'(1);
                            r_state    <= ST_REQ;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    cnn_word_unpack #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (LANES),
        .CNT_W      (LANE_CNT_W)
    ) u_unpack (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .i_load        (w_load),
        .i_word        (mgr_obi_rsp_i.r.rdata),
        .i_count       (w_lane_cnt),
        .pixel_o       (pixel_o),
        .pixel_valid_o (pixel_valid_o),
        .pixel_ready_i (pixel_ready_i),
        .o_word_done   (w_word_done)
    );

endmodule

// File: tb/tb_cnn_pixel_fetch.sv
// -----------------------------------------------------------------------------
// tb_cnn_pixel_fetch
// Directed bench for cnn_pixel_fetch: an OBI memory model answers reads with
// word i = {4i+3, 4i+2, 4i+1, 4i}; expected pixels are queued when a frame is
// started and a monitor pops and compares them as the DUT transfers pixels.
// -----------------------------------------------------------------------------
module tb_cnn_pixel_fetch;
    import cnn_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    obi_req_t    obi_req;
    obi_rsp_t    obi_rsp;
    logic [7:0]  pixel;
    logic        pixel_valid;
    logic        pixel_ready;
    logic        busy;
    logic        done;
    logic        err;

    logic [7:0]  exp_q [$];
    int          n_vec     = 0;
    int          n_err     = 0;
    int          done_cnt  = 0;
    int          xfer_cnt  = 0;
    int          req_idx   = 0;
    int          gnt_delay = 0;
    int          err_word  = -1;
    logic [31:0] cur_base  = 32'h0;
    bit          rnd_ready = 1'b0;
    bit          inject_stray = 1'b0;

    cnn_pixel_fetch dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .start_i       (start),
        .base_addr_i   (base_addr),
        .mgr_obi_req_o (obi_req),
        .mgr_obi_rsp_i (obi_rsp),
        .pixel_o       (pixel),
        .pixel_valid_o (pixel_valid),
        .pixel_ready_i (pixel_ready),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_data(input int idx);
        logic [31:0] d;
        for (int k = 0; k < 4; k++) d[8*k +: 8] = 8'((4 * idx + k) & 255);
        return d;
    endfunction

    // Downstream ready: always 1, or low about 30% of cycles.
    initial begin
        pixel_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            pixel_ready = rnd_ready ? ($urandom_range(0, 99) >= 30) : 1'b1;
        end
    end

    // OBI subordinate: grant after gnt_delay wait cycles, rvalid one cycle
    // after the grant; checks address order and that requests hold steady.
    initial begin : mem_model
        int          wait_cnt;
        int          pend_idx;
        bit          pend;
        logic [31:0] held_addr;
        wait_cnt  = 0;
        pend_idx  = 0;
        pend      = 1'b0;
        held_addr = '0;
        obi_rsp   = '0;
        forever begin
            @(posedge clk); #1;
            obi_rsp = '0;
            if (!rst_n) begin
                pend     = 1'b0;
                wait_cnt = 0;
            end else if (inject_stray) begin
                inject_stray   = 1'b0;
                obi_rsp.rvalid = 1'b1;
                obi_rsp.r.rdata = 32'hDEAD_BEEF;
            end else if (pend) begin
                pend            = 1'b0;
                obi_rsp.rvalid  = 1'b1;
                obi_rsp.r.rdata = word_data(pend_idx);
                obi_rsp.r.err   = (pend_idx == err_word);
                chk("no_req_outstanding", 32'(obi_req.req), 32'd0);
            end else if (obi_req.req || wait_cnt > 0) begin
                if (wait_cnt > 0) begin
                    chk("req_held", 32'(obi_req.req), 32'd1);
                    chk("addr_held", obi_req.a.addr, held_addr);
                end else begin
                    chk("req_addr", obi_req.a.addr, cur_base + 32'(4 * req_idx));
                    chk("req_we_be", {27'd0, obi_req.a.we, obi_req.a.be}, 32'h0F);
                    held_addr = obi_req.a.addr;
                end
                if (obi_req.req && wait_cnt >= gnt_delay) begin
                    obi_rsp.gnt = 1'b1;
                    pend        = 1'b1;
                    pend_idx    = req_idx;
                    req_idx++;
                    wait_cnt    = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Scoreboard monitor: pop and compare on each accepted pixel, and check
    // that a stalled pixel is held unchanged.
    initial begin : monitor
        bit         prev_stall;
        logic [7:0] prev_pix;
        prev_stall = 1'b0;
        prev_pix   = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_valid", 32'(pixel_valid), 32'd1);
                    chk("stall_data", 32'(pixel), 32'(prev_pix));
                end
                if (pixel_valid && pixel_ready) begin
                    if (exp_q.size() == 0) chk("extra_pixel", 32'(pixel_valid), 32'd0);
                    else                   chk("pixel", 32'(pixel), 32'(exp_q.pop_front()));
                    xfer_cnt++;
                end
                if (done) done_cnt++;
                prev_stall = pixel_valid && !pixel_ready;
                prev_pix   = pixel;
            end
        end
    end

    task automatic pulse_start(input logic [31:0] b);
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = b;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic run_frame(input logic [31:0] b, input int gdly, input int errw,
                             input int npix, input bit rnd, input int nreads,
                             input bit exp_err, input string tag);
        int dc0;
        int x0;
        cur_base  = b;
        gnt_delay = gdly;
        err_word  = errw;
        rnd_ready = rnd;
        req_idx   = 0;
        for (int p = 0; p < npix; p++) exp_q.push_back(8'(p & 255));
        dc0 = done_cnt;
        x0  = xfer_cnt;
        pulse_start(b);
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        for (int c = 0; c < 20000 && done_cnt == dc0; c++) @(posedge clk);
        chk({tag, "_done_seen"}, 32'(done_cnt != dc0), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk({tag, "_done_once"}, 32'(done_cnt - dc0), 32'd1);
        chk({tag, "_pixels"}, 32'(xfer_cnt - x0), 32'(npix));
        chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_reads"}, 32'(req_idx), 32'(nreads));
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        exp_q.delete();
        rnd_ready = 1'b0;
        $display("frame %s: base=0x%08h pixels=%0d reads=%0d err=%0b", tag, b,
                 xfer_cnt - x0, req_idx, err);
    endtask

    initial begin : stim
        int dc0;
        int x0;
        rst_n     = 1'b0;
        start     = 1'b0;
        base_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(pixel_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_req", 32'(obi_req.req), 32'd0);
        rst_n = 1'b1;

        run_frame(32'h1A10_0000, 0, -1, 784, 1'b0, 196, 1'b0, "frame");
        run_frame(32'h1A10_0000, 0, -1, 784, 1'b1, 196, 1'b0, "backpressure");
        run_frame(32'h1A10_0000, 3, -1, 784, 1'b0, 196, 1'b0, "gnt_delay");
        run_frame(32'h1A10_0000, 0, 5, 20, 1'b0, 6, 1'b1, "rd_error");

        // Misaligned start: no bus activity, error and done pulse.
        req_idx = 0;
        dc0     = done_cnt;
        pulse_start(32'h1A10_0002);
        chk("misalign_busy", 32'(busy), 32'd0);
        for (int c = 0; c < 20 && done_cnt == dc0; c++) @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        chk("misalign_done", 32'(done_cnt - dc0), 32'd1);
        chk("misalign_err", 32'(err), 32'd1);
        chk("misalign_reads", 32'(req_idx), 32'd0);
        $display("frame misalign: base=0x1a100002 err=%0b reads=%0d", err, req_idx);

        // Reset in the middle of a frame.
        cur_base  = 32'h1A10_0000;
        gnt_delay = 0;
        err_word  = -1;
        req_idx   = 0;
        for (int p = 0; p < 784; p++) exp_q.push_back(8'(p & 255));
        x0 = xfer_cnt;
        pulse_start(32'h1A10_0000);
        for (int c = 0; c < 5000 && (xfer_cnt - x0) < 100; c++) @(negedge clk);
        chk("midrst_reached", 32'(xfer_cnt - x0), 32'd100);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(pixel_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_req", 32'(obi_req.req), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n        = 1'b1;
        req_idx      = 0;
        inject_stray = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("stray_valid", 32'(pixel_valid), 32'd0);
        chk("stray_busy", 32'(busy), 32'd0);
        chk("stray_reads", 32'(req_idx), 32'd0);
        $display("frame midrst: pixels_before_reset=%0d", xfer_cnt - x0);

        run_frame(32'h1A10_0000, 0, -1, 784, 1'b0, 196, 1'b0, "after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "time limit reached");
    end

endmodule
